// File: rtl/tros_meas_if.sv
// Control bundle between the measurement sequencer and its driver:
// run requests in, counter/readout strobes and status out.
interface tros_meas_if #(
  parameter int GATE_WIDTH = 16
);
  logic                  start;
  logic                  continuous;
  logic                  abort;
  logic [GATE_WIDTH-1:0] gate_cycles;
  logic [2:0]            chan_mask;
  logic                  ctr_reset;
  logic                  latch_counter;
  logic                  send_counter;
  logic [1:0]            counter_select;
  logic                  busy;
  logic                  done;
  logic [7:0]            frame_count;

  modport master (
    output start, continuous, abort, gate_cycles, chan_mask,
    input  ctr_reset, latch_counter, send_counter, counter_select, busy, done, frame_count
  );

  modport slave (
    input  start, continuous, abort, gate_cycles, chan_mask,
    output ctr_reset, latch_counter, send_counter, counter_select, busy, done, frame_count
  );
endinterface

// File: rtl/tros_meas_sequencer.sv
// Autonomous clear -> gate -> latch -> per-channel send/drain sequencer for the
// ring-oscillator frequency counter; every output comes straight from a flop.
module tros_meas_sequencer #(
  parameter int GATE_WIDTH = 16,
  parameter int SEND_BITS  = 24,
  parameter int SYNC_WAIT  = 4
) (
  input logic       clk,
  input logic       rst_n,
  tros_meas_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GATE, S_LATCH, S_SEL, S_SEND, S_DRAIN, S_DONE
  } state_t;

  localparam int DRAIN_LEN = SEND_BITS + SYNC_WAIT;
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);
  localparam int CNT_W     = (GATE_WIDTH > DRAIN_W) ? GATE_WIDTH : DRAIN_W;
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] SYNC_LOAD  = CNT_W'(SYNC_WAIT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_LEN - 1);

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [GATE_WIDTH-1:0] gate_reg, gate_next;
  logic [2:0]            mask_reg, mask_next;
  logic [1:0]            chan_reg, chan_next;

  logic       ctr_reset_reg, ctr_reset_next;
  logic       latch_reg, latch_next;
  logic       send_reg, send_next;
  logic [1:0] sel_reg, sel_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic [7:0] frame_count_reg, frame_count_next;

  logic       cnt_zero;
  logic [2:0] above_mask;
  logic [2:0] rest_mask;

  function automatic logic [1:0] lowest_chan(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  assign cnt_zero   = (cnt_reg == '0);
  // Channels strictly above the one just sent; ascending order falls out of this.
  assign above_mask = 3'b110 << chan_reg;
  assign rest_mask  = mask_reg & above_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      gate_reg        <= '0;
      mask_reg        <= '0;
      chan_reg        <= '0;
      ctr_reset_reg   <= 1'b0;
      latch_reg       <= 1'b0;
      send_reg        <= 1'b0;
      sel_reg         <= 2'b11;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      gate_reg        <= gate_next;
      mask_reg        <= mask_next;
      chan_reg        <= chan_next;
      ctr_reset_reg   <= ctr_reset_next;
      latch_reg       <= latch_next;
      send_reg        <= send_next;
      sel_reg         <= sel_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      frame_count_reg <= frame_count_next;
    end
  end

  // Each timed state loads cnt with (duration - 1) on entry and leaves at zero.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_zero ? cnt_reg : cnt_reg - ONE;
    gate_next  = gate_reg;
    mask_next  = mask_reg;
    chan_next  = chan_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next = S_CLEAR;
          cnt_next   = SYNC_LOAD;
          gate_next  = bus.gate_cycles;
          mask_next  = bus.chan_mask;
        end
      end
      S_CLEAR: begin
        if (cnt_zero) begin
          state_next = S_GATE;
          cnt_next   = (gate_reg == '0) ? '0 : CNT_W'(gate_reg) - ONE;
        end
      end
      S_GATE: begin
        if (cnt_zero) begin
          state_next = S_LATCH;
          cnt_next   = SYNC_LOAD;
        end
      end
      S_LATCH: begin
        if (cnt_zero) begin
          if (mask_reg != 3'b000) begin
            state_next = S_SEL;
            chan_next  = lowest_chan(mask_reg);
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_SEL: begin
        state_next = S_SEND;
        cnt_next   = SYNC_LOAD;
      end
      S_SEND: begin
        if (cnt_zero) begin
          state_next = S_DRAIN;
          cnt_next   = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (cnt_zero) begin
          if (rest_mask != 3'b000) begin
            state_next = S_SEL;
            chan_next  = lowest_chan(rest_mask);
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.continuous) begin
          state_next = S_CLEAR;
          cnt_next   = SYNC_LOAD;
          gate_next  = bus.gate_cycles;
          mask_next  = bus.chan_mask;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (bus.abort && state_reg != S_IDLE) state_next = S_IDLE;
  end

  // Outputs are decoded from the next state so they land in flops in step with it.
  always_comb begin
    ctr_reset_next   = (state_next == S_CLEAR);
    latch_next       = (state_next == S_LATCH);
    send_next        = (state_next == S_SEND);
    busy_next        = (state_next != S_IDLE);
    done_next        = (state_next == S_DONE);
    frame_count_next = frame_count_reg;
    if (state_next == S_DONE) frame_count_next = frame_count_reg + 8'd1;
    sel_next = 2'b11;
    if (state_next == S_SEL || state_next == S_SEND || state_next == S_DRAIN) sel_next = chan_next;
  end

  assign bus.ctr_reset      = ctr_reset_reg;
  assign bus.latch_counter  = latch_reg;
  assign bus.send_counter   = send_reg;
  assign bus.counter_select = sel_reg;
  assign bus.busy           = busy_reg;
  assign bus.done           = done_reg;
  assign bus.frame_count    = frame_count_reg;
endmodule
